muldiv_unit: RTL
================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the successor to the pipeline's fixed 32-bit multiplier. It sits in the execute stage, fed by the forwarded `srca_e`/`srcb_e` operands. It supports signed and unsigned multiply and divide, plus MTHI/MTLO writes. Its `busy` output drives the hazard unit's stall logic, and `hi`/`lo` feed the execute-stage output-select mux.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4 and even.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request an operation; sampled only while `busy`=0.
- `op`  in  2  operation select: `op[1]`=divide (1) or multiply (0); `op[0]`=signed (1) or unsigned (0).
- `src_a`  in  WIDTH  multiplicand or dividend.
- `src_b`  in  WIDTH  multiplier or divisor.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight; the hazard unit stalls any dependent MFHI/MFLO/start.
- `done`  out  1  single-cycle pulse: `hi`/`lo` were just updated by an operation.
- `err`  out  1  qualified by `done`: divide-by-zero, or an unsupported op.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN when `start`=1:
  - latch operand magnitudes (two's-complement absolute value when `op[0]`=1);
  - latch result signs;
  - load iteration counter with WIDTH−1.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits.
  - Counter decrements each step; RUN → FIX when counter = 0 at the edge.
- FIX: apply signs, write `hi`/`lo`, pulse `done`, return to IDLE.
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
- Divide by zero (`src_b`=0):
  - `lo` = all ones; `hi` = `src_a` unmodified; `err`=1 with `done`;
  - takes the same latency as a normal divide.
- Signed overflow (most-negative ÷ −1): `lo` = most-negative value, `hi` = 0, `err`=0.
- MTHI/MTLO: `hi_we`/`lo_we` write `wdata` at the edge, only when `busy`=0.
  - Writes while `busy`=1 are dropped.
  - `start` together with `hi_we`/`lo_we`: the write occurs, then the operation overwrites both registers at FIX.
- `start` while `busy`=1: ignored; no queueing.
- `hi`/`lo` hold their value between updates; partial results never appear on them.

## Timing
- Reset values:
  - FSM = IDLE;
  - `busy`=0, `done`=0, `err`=0;
  - `hi`=0, `lo`=0;
  - counter = 0.
- `reset` asserted mid-operation aborts the operation; all outputs take their reset values at that edge.
- Latency, with `start` sampled at edge k:
  - `busy`=1 from k through k+WIDTH;
  - WIDTH RUN edges k+1..k+WIDTH;
  - FIX edge k+WIDTH+1 updates `hi`/`lo` and sets `done`.
- During the `done` cycle, `busy`=0 and `hi`/`lo` are new.
  - A `start` in that same cycle is accepted: back-to-back issue interval is WIDTH+2 cycles.
- `done`/`err` are registered and high for exactly one cycle.

## Configuration
- `MULDIV_DIV_EN` defined: divide datapath, divide-by-zero logic and remainder sign fix are compiled in.
- `MULDIV_DIV_EN` undefined: multiply only.
  - A `start` with `op[1]`=1 does not enter RUN and `busy` stays 0.
  - `done`=1 and `err`=1 on the next cycle.
  - `hi`/`lo` unchanged.
  - Multiply behaviour and timing are identical in both builds.

## Test plan
- WIDTH=32, signed multiply, −3 × 5:
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1;
  - `done` high exactly 34 cycles after the start cycle, `err`=0.
- Unsigned multiply, 0xFFFFFFFF × 0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed divide, −7 ÷ 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Unsigned divide, 100 ÷ 0: `lo`=0xFFFFFFFF, `hi`=0x00000064, `err`=1 with `done`.
- A second `start` and an `hi_we`/`wdata`=0x1234 issued mid-operation are both ignored.
  - `hi`/`lo` show only the first result.
  - A `start` during the `done` cycle is accepted.
- `reset` at RUN cycle 10:
  - all outputs 0 at the next cycle;
  - no `done` pulse follows;
  - a fresh multiply of 6 × 7 then gives `lo`=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit with HI/LO registers.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise multiply-only.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hw;
  logic [WIDTH-1:0] r_lw;
  logic             r_neg;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic               w_unsup;

  assign w_mag_a = (i_op[0] && i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
  assign w_mag_b = (i_op[0] && i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;

  // Shift-add: {r_hw, r_lw} is the 2*WIDTH accumulator, r_lw holds multiplier bits.
  assign w_addend = r_lw[0] ? r_b : '0;
  assign w_sum    = {1'b0, r_hw} + {1'b0, w_addend};

  assign w_prod     = {r_hw, r_lw};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
  logic             r_div;
  logic             r_rneg;
  logic             r_dz;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // Restoring step: r_hw is the remainder, r_lw shifts dividend out and quotient in.
  assign w_shift = {r_hw, r_lw[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;
  assign w_quo   = r_neg  ? -r_lw : r_lw;
  assign w_rem   = r_rneg ? -r_hw : r_hw;
  assign w_unsup = 1'b0;
`else
  assign w_unsup = i_op[1];
`endif

  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = r_dz ? '1 : w_quo;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_hw    <= '0;
      r_lw    <= '0;
      r_neg   <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div   <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (i_start && w_unsup) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end else if (i_start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH - 1);
            r_hw    <= '0;
            r_neg   <= i_op[0] & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            r_div   <= i_op[1];
            r_rneg  <= i_op[0] & i_src_a[WIDTH-1];
            r_dz    <= i_op[1] & (i_src_b == '0);
            r_b     <= i_op[1] ? w_mag_b : w_mag_a;
            r_lw    <= i_op[1] ? w_mag_a : w_mag_b;
`else
            r_b     <= w_mag_a;
            r_lw    <= w_mag_b;
`endif
          end
        end
        S_RUN: begin
`ifdef MULDIV_DIV_EN
          if (r_div) begin
            r_hw <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_lw <= {r_lw[WIDTH-2:0], w_ge};
          end else
`endif
          begin
            r_hw <= w_sum[WIDTH:1];
            r_lw <= {w_sum[0], r_lw[WIDTH-1:1]};
          end
          if (r_cnt == '0) r_state <= S_FIX;
          else r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
`ifdef MULDIV_DIV_EN
          r_err   <= r_dz;
`endif
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
